// File: rtl/cfglut_kd.sv
// Runtime-reconfigurable K-input dual-output LUT, loaded over a cascadable CDI/CDO shift chain.
// With SHADOW=1 the table is staged in a shadow register and swapped in atomically after 2**K bits.
module cfglut_kd #(
  parameter int                 K      = 5,
  parameter logic [(1<<K)-1:0]  INIT   = '0,
  parameter bit                 SHADOW = 1'b0
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         CE,
  input  logic         CDI,
  input  logic         ABORT,
  input  logic [K-1:0] I,
  output logic         O,
  output logic         LO,
  output logic         CDO,
  output logic         CFG_DONE
);

  localparam int N = 1 << K;

  logic [N-1:0] r_active;
  logic         r_done;

  // Lookup is purely combinational so a table swap shows on the same edge.
  assign O        = r_active[I];
  assign LO       = r_active[{1'b0, I[K-2:0]}];
  assign CFG_DONE = r_done;

  if (SHADOW == 1'b0) begin : g_direct
    logic w_unused_abort;
    assign w_unused_abort = ABORT;
    assign CDO            = r_active[N-1];

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        r_active <= INIT;
        r_done   <= 1'b0;
      end else begin
        r_done <= CE;
        if (CE) r_active <= {r_active[N-2:0], CDI};
      end
    end
  end else begin : g_shadow
    logic [N-1:0] r_shreg;
    logic [K-1:0] r_cnt;
    logic         w_last;

    // r_cnt == 0 is the idle state; any other value means a load is in flight.
    assign w_last = (r_cnt == K'(N - 1));
    assign CDO    = r_shreg[N-1];

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        r_active <= INIT;
        r_shreg  <= INIT;
        r_cnt    <= '0;
        r_done   <= 1'b0;
      end else if (ABORT) begin
        r_shreg  <= r_active;
        r_cnt    <= '0;
        r_done   <= 1'b0;
      end else if (CE) begin
        r_shreg  <= {r_shreg[N-2:0], CDI};
        r_cnt    <= r_cnt + K'(1);
        r_done   <= w_last;
        if (w_last) r_active <= {r_shreg[N-2:0], CDI};
      end else begin
        r_done   <= 1'b0;
      end
    end
  end

endmodule
